// File: rtl/osc_pkg.sv
// Shared types for the multi-channel oscillator.
// Build option: OSC_HARD_SYNC_EN enables per-channel hard sync.
package osc_pkg;

  typedef enum logic [1:0] {
    SAW_UP = 2'd0,
    SAW_DN = 2'd1,
    TRI    = 2'd2,
    PULSE  = 2'd3
  } wave_mode_e;

  // Storage widths; the top slices down to PHASE_W / ADDR_W.
  localparam int CFG_INC_W = 32;
  localparam int CFG_PW_W  = 16;

  typedef struct packed {
    logic                 en;
    wave_mode_e           mode;
    logic [CFG_INC_W-1:0] inc;
    logic [CFG_PW_W-1:0]  pw;
  } osc_cfg_t;

  // Mid-scale pulse width: 2^(addr_w-1).
  function automatic logic [CFG_PW_W-1:0] def_pw(
    input int addr_w
  );
    return CFG_PW_W'(1) << (addr_w - 1);
  endfunction

  function automatic osc_cfg_t cfg_rst(
    input int addr_w
  );
    osc_cfg_t c;
    c.en   = 1'b0;
    c.mode = SAW_UP;
    c.inc  = '0;
    c.pw   = def_pw(addr_w);
    return c;
  endfunction

endpackage

// File: rtl/osc_wave_shaper.sv
// Combinational waveform map from a phase address
// to a signed sample.
module osc_wave_shaper
  import osc_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int OUT_W  = 16
) (
  input  logic [ADDR_W-1:0]       a,
  input  wave_mode_e              mode,
  input  logic [ADDR_W-1:0]       pw,
  input  logic                    en,
  output logic signed [OUT_W-1:0] y
);

  localparam int S = OUT_W - ADDR_W;
  localparam logic [OUT_W-1:0] MIN_V =
    {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MAX_V = ~MIN_V;

  logic [ADDR_W-1:0] t;
  logic [OUT_W-1:0]  up;
  logic [OUT_W-1:0]  dn;
  logic [OUT_W-1:0]  tri_v;

  // Raw shapes; subtracting 2^(OUT_W-1) is an MSB flip.
  always_comb begin
    t     = a[ADDR_W-1] ? ~a : a;
    up    = (OUT_W'(a) << S) ^ MIN_V;
    dn    = (up == MIN_V) ? MAX_V : -up;
    tri_v = (OUT_W'(t) << (S + 1)) ^ MIN_V;
  end

  // Mode select; disabled channels output zero.
  always_comb begin
    y = '0;
    if (en) begin
      unique case (mode)
        SAW_UP: y = up;
        SAW_DN: y = dn;
        TRI:    y = tri_v;
        PULSE:  y = (a < pw) ? MAX_V : MIN_V;
      endcase
    end
  end

endmodule

// File: rtl/multi_wave_osc.sv
// Time-multiplexed multi-channel oscillator.
// Build option: OSC_HARD_SYNC_EN adds sync_mask input.
module multi_wave_osc
  import osc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 9,
  parameter int OUT_W   = 16,
  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_en,
  input  logic [1:0]              cfg_mode,
  input  logic [PHASE_W-1:0]      cfg_inc,
  input  logic [ADDR_W-1:0]       cfg_pw,
`ifdef OSC_HARD_SYNC_EN
  input  logic [NUM_CH-1:0]       sync_mask,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [CH_W-1:0] LAST_CH =
    CH_W'(NUM_CH - 1);

  state_e state_q;
  state_e state_d;

  logic            ev;
  logic [CH_W-1:0] ev_ch;

  osc_cfg_t           cfg_q   [NUM_CH];
  logic [PHASE_W-1:0] phase_q [NUM_CH];

  osc_cfg_t              ev_cfg;
  osc_cfg_t              wr_cfg;
  logic [PHASE_W-1:0]    ev_ph;
  logic [PHASE_W-1:0]    ev_inc;
  logic [PHASE_W-1:0]    nxt_ph;
  logic [ADDR_W-1:0]     ev_a;
  logic                  ev_sync;
  logic signed [OUT_W-1:0] ev_y;
  logic                  unused_cfg;

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Walk control: pick the channel to evaluate this edge.
  always_comb begin
    state_d = state_q;
    ev      = 1'b0;
    ev_ch   = '0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          ev      = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (out_ch == LAST_CH) begin
            state_d = IDLE;
          end else begin
            ev    = 1'b1;
            ev_ch = out_ch + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch the evaluated channel and form its next phase.
  always_comb begin
    ev_cfg  = cfg_q[ev_ch];
    ev_ph   = phase_q[ev_ch];
    ev_inc  = ev_cfg.inc[PHASE_W-1:0];
`ifdef OSC_HARD_SYNC_EN
    ev_sync = sync_mask[ev_ch];
`else
    ev_sync = 1'b0;
`endif
    ev_a    = ev_sync ? '0
                      : ev_ph[PHASE_W-1 -: ADDR_W];
    nxt_ph  = ev_sync ? ev_inc : ev_ph + ev_inc;
    unused_cfg = ^{ev_cfg.inc, ev_cfg.pw};
  end

  // Incoming config record, widened to storage size.
  always_comb begin
    wr_cfg.en   = cfg_en;
    wr_cfg.mode = wave_mode_e'(cfg_mode);
    wr_cfg.inc  = CFG_INC_W'(cfg_inc);
    wr_cfg.pw   = CFG_PW_W'(cfg_pw);
  end

  osc_wave_shaper #(
    .ADDR_W (ADDR_W),
    .OUT_W  (OUT_W)
  ) u_shaper (
    .a    (ev_a),
    .mode (ev_cfg.mode),
    .pw   (ev_cfg.pw[ADDR_W-1:0]),
    .en   (ev_cfg.en),
    .y    (ev_y)
  );

  // Output register, phase RAM and config RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_ch   <= '0;
      out_last <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= '0;
        cfg_q[i]   <= cfg_rst(ADDR_W);
      end
    end else begin
      overrun <= tick && (state_q == RUN);
      if (ev) begin
        out_data <= ev_y;
        out_ch   <= ev_ch;
        out_last <= (ev_ch == LAST_CH);
        if (ev_cfg.en) phase_q[ev_ch] <= nxt_ph;
      end
      if (cfg_we && (int'(cfg_ch) < NUM_CH))
        cfg_q[cfg_ch] <= wr_cfg;
    end
  end

endmodule

// File: tb/tb_multi_wave_osc.sv
// Directed bench for multi_wave_osc.
// Default build (no hard sync).
module tb_multi_wave_osc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        tick;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic        cfg_en;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_inc;
  logic [8:0]  cfg_pw;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic signed [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int got [4];
  int hold;
  int n_ovr;

  typedef struct {
    string name;
    int    d [4];
  } vec_t;

  vec_t vecs [4];

  multi_wave_osc dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_en    (cfg_en),
    .cfg_mode  (cfg_mode),
    .cfg_inc   (cfg_inc),
    .cfg_pw    (cfg_pw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int m_saw(input int w);
    return (w % 512) * 128 - 32768;
  endfunction

  function automatic int m_tri(input int w);
    int a;
    int t;
    a = (w * 255) % 512;
    t = (a < 256) ? a : 511 - a;
    return t * 256 - 32768;
  endfunction

  function automatic int m_pul(input int w);
    return ((w % 512) < 128) ? 32767 : -32768;
  endfunction

  task automatic write_cfg(input int ch,
                           input int en,
                           input int mode,
                           input int inc,
                           input int pw);
    cfg_ch   = 2'(ch);
    cfg_en   = en[0];
    cfg_mode = 2'(mode);
    cfg_inc  = 24'(inc);
    cfg_pw   = 9'(pw);
    cfg_we   = 1'b1;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Full walk with out_ready high; wr_at>=0 raises
  // cfg_we while that slot is shown (so the write
  // lands on the edge evaluating slot wr_at+1).
  task automatic do_walk(input int wr_at);
    tick      = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("walk_valid%0d", k),
          int'(out_valid), 1);
      chk($sformatf("walk_ch%0d", k),
          int'(out_ch), k);
      chk($sformatf("walk_last%0d", k),
          int'(out_last), (k == 3) ? 1 : 0);
      got[k] = out_data;
      if (k == wr_at) cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
    end
    chk("walk_end_valid", int'(out_valid), 0);
    chk("walk_end_busy", int'(busy), 0);
  endtask

  initial begin
    reset     = 1'b1;
    tick      = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_en    = 1'b0;
    cfg_mode  = '0;
    cfg_inc   = '0;
    cfg_pw    = '0;
    out_ready = 1'b1;

    vecs[0] = '{"off", '{0, 0, 0, 0}};
    vecs[1] = '{"w0",
                '{-32768, -32768, 32767, 32767}};
    vecs[2] = '{"w1",
                '{-32640, 32512, 32767, 32767}};
    vecs[3] = '{"w2",
                '{-32512, -32512, 32767, 32767}};

    repeat (3) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ch", int'(out_ch), 0);
    chk("rst_last", int'(out_last), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        write_cfg(0, 1, 0, 24'h008000, 0);
        write_cfg(1, 1, 2, 24'h7f8000, 0);
        write_cfg(2, 1, 1, 0, 0);
        write_cfg(3, 1, 3, 24'h008000, 128);
      end
      do_walk(-1);
      for (int c = 0; c < 4; c++)
        chk($sformatf("%s_ch%0d", vecs[i].name, c),
            got[c], vecs[i].d[c]);
    end

    for (int w = 3; w <= 512; w++) begin
      do_walk(-1);
      chk($sformatf("saw_w%0d", w), got[0], m_saw(w));
      chk($sformatf("tri_w%0d", w), got[1], m_tri(w));
      chk($sformatf("dn_w%0d", w), got[2], 32767);
      chk($sformatf("pul_w%0d", w), got[3], m_pul(w));
    end

    write_cfg(3, 1, 3, 24'h008000, 0);
    do_walk(-1);
    chk("pw0_ch3", got[3], -32768);
    chk("pw0_ch0", got[0], m_saw(513));
    do_walk(-1);
    chk("pw0b_ch3", got[3], -32768);

    tick      = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("stall_ch0", int'(out_data), m_saw(515));
    @(negedge clk);
    hold = out_data;
    chk("stall_ch1_val", hold, m_tri(515));
    out_ready = 1'b0;
    n_ovr = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_ch", int'(out_ch), 1);
      chk("stall_data", int'(out_data), hold);
      if (overrun) n_ovr++;
      tick = (i == 1);
      @(negedge clk);
    end
    tick = 1'b0;
    if (overrun) n_ovr++;
    chk("ovr_count", n_ovr, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("resume_ch2", int'(out_ch), 2);
    @(negedge clk);
    chk("resume_ch3", int'(out_ch), 3);
    chk("resume_last", int'(out_last), 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("lost_tick", int'(out_valid), 0);
      @(negedge clk);
    end
    do_walk(-1);
    chk("post_ch0", got[0], m_saw(516));
    chk("post_ch1", got[1], m_tri(516));

    cfg_ch   = 2'd2;
    cfg_en   = 1'b1;
    cfg_mode = 2'd0;
    cfg_inc  = '0;
    cfg_pw   = 9'd256;
    do_walk(1);
    chk("same_edge_old", got[2], 32767);
    do_walk(-1);
    chk("same_edge_new", got[2], -32768);

    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_ch", int'(out_ch), 0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("after_rst_valid", int'(out_valid), 0);
    end
    for (int c = 0; c < 4; c++)
      write_cfg(c, 1, 0, 24'h008000, 256);
    do_walk(-1);
    for (int c = 0; c < 4; c++)
      chk($sformatf("ph0_ch%0d", c), got[c], -32768);
    do_walk(-1);
    for (int c = 0; c < 4; c++)
      chk($sformatf("ph1_ch%0d", c), got[c], -32640);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
